// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller that sits directly in front of
// dual_port_ram. It turns a push/pop handshake into RAM write/read strobes
// and addresses. It also keeps the wrapping pointers, the occupancy count,
// the status flags and the sticky error flags. The RAM's registered read
// data is passed back to the client, qualified by rd_valid.
module fifo_ctrl #(
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_DEPTH  = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_LEVEL   = 240
) (
  input  logic                  clk,
  input  logic                  rst,
  // client push side
  input  logic                  wr_req,
  input  logic [RAM_WIDTH-1:0]  wr_data,
  // client pop side
  input  logic                  rd_req,
  output logic [RAM_WIDTH-1:0]  rd_data,
  output logic                  rd_valid,
  // status
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err,
  // RAM write port
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [RAM_WIDTH-1:0]  ram_data_in,
  // RAM read port
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [RAM_WIDTH-1:0]  ram_data_out
);

  // count is one bit wider than the pointers, so a full FIFO (RAM_DEPTH)
  // is distinct from an empty one (0).
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_COUNT   = (ADDR_WIDTH+1)'(AF_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // The flags are decoded from the registered count. A push while full is
  // rejected even when a pop happens in the same cycle, and a pop while
  // empty is rejected even when a push happens in the same cycle.
  assign full        = (count == FULL_COUNT);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_COUNT);

  assign wr_acc = wr_req & ~full;
  assign rd_acc = rd_req & ~empty;

  // The RAM strobes are combinational, so the RAM acts in the same cycle as
  // the accepted request. The addresses are the current pointers.
  assign ram_wr_en   = wr_acc;
  assign ram_wr_addr = wr_ptr;
  assign ram_data_in = wr_data;
  assign ram_rd_en   = rd_acc;
  assign ram_rd_addr = rd_ptr;

  // The RAM already registers its read data, so it is passed straight through.
  assign rd_data = ram_data_out;

  // Write pointer: advances on each accepted push and wraps by natural
  // overflow. The RAM is outside this block and is never cleared: after a
  // reset its old contents are simply unreachable behind the pointers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge value of every other register.
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_acc) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Read pointer: advances on each accepted pop and wraps by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (rd_acc) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: a push alone adds one, a pop alone removes one, and a push
  // with a pop in the same cycle leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Read-data qualifier: the RAM presents the popped entry one cycle after
  // the pop. Reset wins, so a pop accepted during reset produces no rd_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
    end
  end

  // Sticky overflow: set by a push attempted while full. When a set and
  // clr_err happen in the same cycle, the set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_req && full) begin
      overflow <= 1'b1;
    end else if (clr_err) begin
      overflow <= 1'b0;
    end
  end

  // Sticky underflow: set by a pop attempted while empty. When a set and
  // clr_err happen in the same cycle, the set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (rd_req && empty) begin
      underflow <= 1'b1;
    end else if (clr_err) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed test of fifo_ctrl connected to a behavioural
// dual_port_ram model (synchronous write, registered read). Inputs change
// 1 ns after each rising edge, and outputs are checked there as well.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [8:0] count;
  logic       overflow;
  logic       underflow;
  logic       clr_err;
  logic       ram_wr_en;
  logic [7:0] ram_wr_addr;
  logic [7:0] ram_data_in;
  logic       ram_rd_en;
  logic [7:0] ram_rd_addr;
  logic [7:0] ram_data_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  logic [7:0] exp_rd;
  logic       exp_rd_pending;

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .wr_data      (wr_data),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_data_in  (ram_data_in),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_data_out (ram_data_out)
  );

  // Behavioural dual_port_ram: write on the edge, registered read data.
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_data_in;
    if (ram_rd_en) ram_data_out <= mem[ram_rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; wr_data = '0; rd_req = 1'b0; clr_err = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_count",     count,       0);
    check("rst_empty",     empty,       1);
    check("rst_full",      full,        0);
    check("rst_af",        almost_full, 0);
    check("rst_rd_valid",  rd_valid,    0);
    check("rst_overflow",  overflow,    0);
    check("rst_underflow", underflow,   0);
    check("rst_wr_addr",   ram_wr_addr, 0);
    check("rst_rd_addr",   ram_rd_addr, 0);

    // 1: fill with 0x00..0xFF
    for (int i = 0; i < 256; i++) begin
      wr_req = 1'b1; wr_data = 8'(i);
      #1;
      check("fill_wr_en", ram_wr_en, 1);
      tick();
      check("fill_count", count, i + 1);
      check("fill_af",    almost_full, (i + 1 >= 240) ? 1 : 0);
      check("fill_full",  full, (i == 255) ? 1 : 0);
    end
    wr_req = 1'b0;
    check("fill_empty", empty, 0);

    // 2: a push while full is rejected and sets overflow; clr_err clears it
    wr_req = 1'b1; wr_data = 8'hAA;
    #1;
    check("ovf_wr_en", ram_wr_en, 0);
    tick();
    check("ovf_count", count, 256);
    check("ovf_flag",  overflow, 1);
    check("ovf_udf",   underflow, 0);
    clr_err = 1'b1;            // set and clear together: set wins
    tick();
    check("ovf_set_wins", overflow, 1);
    wr_req = 1'b0;
    tick();
    clr_err = 1'b0;
    check("ovf_cleared", overflow, 0);
    check("ovf_count2",  count, 256);
    check("pre_pop_rd_valid", rd_valid, 0);

    // 3: 256 back-to-back pops
    for (int k = 0; k < 256; k++) begin
      rd_req = 1'b1;
      #1;
      check("drain_rd_en", ram_rd_en, 1);
      tick();
      check("drain_rd_valid", rd_valid, 1);
      check("drain_rd_data",  rd_data, k);
      check("drain_count",    count, 255 - k);
    end
    rd_req = 1'b0;
    check("drain_empty", empty, 1);
    check("drain_full",  full, 0);
    tick();
    check("drain_rd_valid_off", rd_valid, 0);

    // 4: a pop while empty is rejected; a push in the same cycle is accepted
    rd_req = 1'b1; wr_req = 1'b1; wr_data = 8'h5C;
    #1;
    check("udf_rd_en", ram_rd_en, 0);
    check("udf_wr_en", ram_wr_en, 1);
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    check("udf_rd_valid", rd_valid, 0);
    check("udf_flag",     underflow, 1);
    check("udf_count",    count, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("udf_cleared", underflow, 0);
    exp_q.push_back(8'h5C);

    // 5: build up to count=5, then push and pop together for 300 cycles
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_data = 8'(8'h60 + i);
      exp_q.push_back(8'(8'h60 + i));
      tick();
    end
    wr_req = 1'b0;
    check("ss_count_init", count, 5);
    check("ss_wr_addr0",   ram_wr_addr, 5);
    check("ss_rd_addr0",   ram_rd_addr, 0);
    for (int i = 0; i < 300; i++) begin
      wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'(i * 7 + 3);
      exp_q.push_back(8'(i * 7 + 3));
      exp_rd = exp_q.pop_front();
      tick();
      check("ss_rd_valid", rd_valid, 1);
      check("ss_rd_data",  rd_data, exp_rd);
      check("ss_count",    count, 5);
    end
    wr_req = 1'b0; rd_req = 1'b0;
    // 300 moves: rd 0 -> 300 mod 256 = 44, wr 5 -> 305 mod 256 = 49
    check("ss_rd_addr_wrap", ram_rd_addr, 44);
    check("ss_wr_addr_wrap", ram_wr_addr, 49);

    // Pop one more entry to confirm the order survived the pointer wrap.
    rd_req = 1'b1;
    exp_rd = exp_q.pop_front();
    exp_rd_pending = 1'b1;
    tick();
    rd_req = 1'b0;
    check("post_wrap_rd_valid", rd_valid, exp_rd_pending);
    check("post_wrap_rd_data",  rd_data, exp_rd);
    check("post_wrap_count",    count, 4);

    // 6: fill to count=100, then reset during a push/pop burst
    for (int i = 0; i < 96; i++) begin
      wr_req = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_req = 1'b0;
    check("burst_count", count, 100);
    rst = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
    tick();
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    check("mid_rst_count",    count, 0);
    check("mid_rst_empty",    empty, 1);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_wr_addr",  ram_wr_addr, 0);
    check("mid_rst_rd_addr",  ram_rd_addr, 0);
    check("mid_rst_af",       almost_full, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
